mac_sequencer: RTL and testbench



---
 rtl/mac_seq_pkg.sv | 19 +
 rtl/mac_sequencer.sv | 137 +++++++++++++
 tb/tb_mac_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the complex MAC sequencer.
package mac_seq_pkg;

    localparam int unsigned CPLX_W = 32;
    localparam int unsigned HALF_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        HOLD
    } mac_seq_state_t;

    typedef struct packed {
        logic [HALF_W-1:0] re;
        logic [HALF_W-1:0] im;
    } cplx_t;

endpackage

// File: rtl/mac_sequencer.sv
// Control front end for the complex multiply-accumulate unit: streams one
// dot-product job into the unit and presents the final value on a result port.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [LEN_W-1:0]  job_len,
    input  logic [CPLX_W-1:0] job_init,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [CPLX_W-1:0] op_x,
    input  logic [CPLX_W-1:0] op_y,
    output logic [CPLX_W-1:0] mac_x,
    output logic [CPLX_W-1:0] mac_y,
    output logic [CPLX_W-1:0] mac_accum,
    output logic              mac_is_load,
    output logic              mac_enable,
    input  logic [CPLX_W-1:0] mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CPLX_W-1:0] res_data,
    output logic              busy
);

    mac_seq_state_t    state_q;
    mac_seq_state_t    state_d;
    logic [LEN_W-1:0]  remain_q;
    logic              first_q;
    cplx_t             init_q;
    logic [CPLX_W-1:0] res_q;

    logic job_take;
    logic beat_take;

    assign job_take  = job_valid && job_ready;
    assign beat_take = op_valid && op_ready;
    assign res_data  = res_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs are gated by RST so they read 0 before the first reset edge.
    always_comb begin
        state_d     = state_q;
        job_ready   = 1'b0;
        op_ready    = 1'b0;
        mac_x       = '0;
        mac_y       = '0;
        mac_accum   = '0;
        mac_is_load = 1'b0;
        mac_enable  = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        if (!RST) begin
            case (state_q)
                IDLE: begin
                    job_ready = 1'b1;
                    if (job_valid) begin
                        state_d = (job_len == '0) ? HOLD : STREAM;
                    end
                end
                STREAM: begin
                    busy        = 1'b1;
                    op_ready    = 1'b1;
                    mac_x       = op_x;
                    mac_y       = op_y;
                    mac_enable  = op_valid;
                    mac_is_load = first_q;
                    mac_accum   = init_q;
                    if (op_valid && (remain_q == LEN_W'(1))) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    busy    = 1'b1;
                    state_d = HOLD;
                end
                HOLD: begin
                    busy      = 1'b1;
                    res_valid = 1'b1;
                    if (res_ready) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            remain_q <= '0;
            first_q  <= 1'b0;
            init_q   <= '0;
            res_q    <= '0;
        end else begin
            if (job_take) begin
                init_q   <= job_init;
                remain_q <= job_len;
                first_q  <= 1'b1;
                // A zero-length job never touches the unit; its result is the seed.
                if (job_len == '0) begin
                    res_q <= job_init;
                end
            end
            if (beat_take) begin
                first_q  <= 1'b0;
                remain_q <= remain_q - LEN_W'(1);
            end
            if (state_q == DRAIN) begin
                res_q <= mac_result;
            end
        end
    end

    a_enable_only_on_beat: assert property (@(posedge CLK) disable iff (RST)
        mac_enable |-> (op_valid && op_ready));

    a_stream_has_work: assert property (@(posedge CLK) disable iff (RST)
        (state_q == STREAM) |-> (remain_q != '0));

    a_result_stable: assert property (@(posedge CLK) disable iff (RST)
        (res_valid && !res_ready) |=> (res_valid && $stable(res_data)));

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer paired with a behavioural complex MAC unit.
module tb_mac_sequencer;

    localparam int LEN_W  = 8;
    localparam int BUDGET = 700;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [LEN_W-1:0] job_len = '0;
    logic [31:0]      job_init = '0;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [31:0]      op_x = '0;
    logic [31:0]      op_y = '0;
    logic [31:0]      mac_x;
    logic [31:0]      mac_y;
    logic [31:0]      mac_accum;
    logic             mac_is_load;
    logic             mac_enable;
    logic [31:0]      mac_result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] xs[256];
    logic [31:0] ys[256];

    always #5 CLK = ~CLK;

    mac_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_init(job_init),
        .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_y(op_y),
        .mac_x(mac_x), .mac_y(mac_y), .mac_accum(mac_accum),
        .mac_is_load(mac_is_load), .mac_enable(mac_enable), .mac_result(mac_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
    );

    // Behavioural MAC unit: 16-bit wraparound products, output straight from its register.
    function automatic logic [31:0] unit_step(input logic [31:0] acc, input logic [31:0] x,
                                              input logic [31:0] y);
        logic [31:0] re;
        logic [31:0] im;
        re = 32'(acc[31:16]) + 32'(x[31:16]) * 32'(y[31:16]) - 32'(x[15:0]) * 32'(y[15:0]);
        im = 32'(acc[15:0]) + 32'(x[31:16]) * 32'(y[15:0]) + 32'(x[15:0]) * 32'(y[31:16]);
        return {re[15:0], im[15:0]};
    endfunction

    logic [31:0] unit_acc = '0;
    always @(posedge CLK) begin
        if (mac_enable) unit_acc <= unit_step(mac_is_load ? mac_accum : unit_acc, mac_x, mac_y);
    end
    assign mac_result = unit_acc;

    // Reference: init + sum of complex products, folded to 16 bits per half at the end.
    function automatic logic [31:0] ref_dot(input int len, input logic [31:0] init);
        longint re;
        longint im;
        longint a, b, c, d;
        re = longint'(signed'(init[31:16]));
        im = longint'(signed'(init[15:0]));
        for (int i = 0; i < len; i++) begin
            a = longint'(signed'(xs[i][31:16]));
            b = longint'(signed'(xs[i][15:0]));
            c = longint'(signed'(ys[i][31:16]));
            d = longint'(signed'(ys[i][15:0]));
            re = re + a * c - b * d;
            im = im + a * d + b * c;
        end
        return {re[15:0], im[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_job(input string tag, input int len, input logic [31:0] init,
                           input int stall_after, input int stall_len, input int rr_delay,
                           input bit junk, input logic [31:0] exp_res, input int exp_lat);
        int beats = 0, stalled = 0, lat = -1, hold_cyc = 0;
        int n_en = 0, n_load = 0, bad_en = 0, extra_rdy = 0, jr_bad = 0, st_bad = 0;
        logic [31:0] res = '0;
        bit seen = 0, done = 0;

        @(posedge CLK); #1;
        job_valid = 1'b1;
        job_len   = LEN_W'(len);
        job_init  = init;
        @(negedge CLK);
        check({tag, ":job_ready_idle"}, 32'(job_ready), 32'd1);
        @(posedge CLK); #1;
        job_valid = 1'b0;
        job_len   = LEN_W'($urandom);
        job_init  = $urandom;

        for (int cyc = 1; cyc <= BUDGET && !done; cyc++) begin
            if (beats < len) begin
                if (beats == stall_after && stalled < stall_len) begin
                    op_valid = 1'b0;
                    op_x     = $urandom;
                    op_y     = $urandom;
                    stalled++;
                end else begin
                    op_valid = 1'b1;
                    op_x     = xs[beats];
                    op_y     = ys[beats];
                end
            end else begin
                op_valid = junk;
                op_x     = $urandom;
                op_y     = $urandom;
            end
            res_ready = seen && (hold_cyc >= rr_delay);
            @(negedge CLK);
            if (mac_enable) n_en++;
            if (mac_enable && mac_is_load) n_load++;
            if (mac_enable && !op_valid) bad_en++;
            if (beats >= len && op_ready) extra_rdy++;
            if (job_ready) jr_bad++;
            if (res_valid) begin
                if (!seen) begin
                    seen = 1;
                    lat  = cyc;
                    res  = res_data;
                end else if (res_data !== res) begin
                    st_bad++;
                end
                if (res_ready) done = 1;
                hold_cyc++;
            end
            if (op_valid && op_ready && beats < len) beats++;
            @(posedge CLK); #1;
        end
        op_valid  = 1'b0;
        res_ready = 1'b0;

        check({tag, ":completed"}, 32'(done), 32'd1);
        check({tag, ":res_data"}, res, exp_res);
        check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ":enable_beats"}, 32'(n_en), 32'(len));
        check({tag, ":load_beats"}, 32'(n_load), (len > 0) ? 32'd1 : 32'd0);
        check({tag, ":enable_without_valid"}, 32'(bad_en), 32'd0);
        check({tag, ":op_ready_outside_stream"}, 32'(extra_rdy), 32'd0);
        check({tag, ":job_ready_while_busy"}, 32'(jr_bad), 32'd0);
        check({tag, ":res_stable"}, 32'(st_bad), 32'd0);
        @(negedge CLK);
        check({tag, ":job_ready_after"}, 32'(job_ready), 32'd1);
        check({tag, ":idle_not_busy"}, 32'(busy), 32'd0);
    endtask

    typedef struct {
        string       tag;
        int          len;
        logic [31:0] init;
        logic [31:0] x;
        logic [31:0] y;
        int          stall_after;
        int          stall_len;
        int          rr_delay;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        vecs[0] = '{"basic",  1,   32'h00010001, 32'h00010002, 32'h00030004, 0, 0, 0,  32'hFFFC000B, 3};
        vecs[1] = '{"multi",  3,   32'h00010001, 32'h00010002, 32'h00030004, 0, 0, 0,  32'hFFF2001F, 5};
        vecs[2] = '{"stall",  3,   32'h00010001, 32'h00010002, 32'h00030004, 1, 4, 0,  32'hFFF2001F, 9};
        vecs[3] = '{"zero",   0,   32'h12345678, 32'h00010002, 32'h00030004, 0, 0, 10, 32'h12345678, 1};
        vecs[4] = '{"b2b_a",  2,   32'h00010001, 32'h00010002, 32'h00030004, 0, 0, 0,  32'hFFF70015, 4};
        vecs[5] = '{"b2b_b",  2,   32'h00020003, 32'h00010002, 32'h00030004, 0, 0, 0,  32'hFFF80017, 4};
        vecs[6] = '{"maxlen", 255, 32'h00010001, 32'h00010002, 32'h00030004, 0, 0, 1,  32'hFB0609F7, 257};

        // Reset state: outputs forced low while RST is high, registers cleared after an edge.
        @(negedge CLK);
        check("rst:outputs_low",
              {27'd0, job_ready, op_ready, mac_enable, res_valid, busy}, 32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst:res_data", res_data, 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rst:job_ready_after_release", 32'(job_ready), 32'd1);
        check("rst:busy_after_release", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < 256; k++) begin
                xs[k] = vecs[i].x;
                ys[k] = vecs[i].y;
            end
            run_job(vecs[i].tag, vecs[i].len, vecs[i].init, vecs[i].stall_after,
                    vecs[i].stall_len, vecs[i].rr_delay, (i % 2) == 1,
                    vecs[i].exp_res, vecs[i].exp_lat);
        end

        // Reset after the first of three beats: job discarded, next job starts clean.
        @(posedge CLK); #1;
        job_valid = 1'b1;
        job_len   = LEN_W'(3);
        job_init  = 32'h00010001;
        @(posedge CLK); #1;
        job_valid = 1'b0;
        op_valid  = 1'b1;
        op_x      = 32'h00010002;
        op_y      = 32'h00030004;
        @(negedge CLK);
        check("midrst:first_beat_load", {30'd0, mac_enable, mac_is_load}, 32'd3);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        check("midrst:handshakes_low",
              {27'd0, job_ready, op_ready, mac_enable, res_valid, busy}, 32'd0);
        check("midrst:mac_x_low", mac_x, 32'd0);
        check("midrst:mac_accum_low", {mac_accum[31:1], mac_is_load}, 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("midrst:res_data", res_data, 32'd0);
        @(posedge CLK); #1;
        RST      = 1'b0;
        op_valid = 1'b0;
        @(negedge CLK);
        check("midrst:job_ready", 32'(job_ready), 32'd1);
        for (int k = 0; k < 256; k++) begin
            xs[k] = 32'h00010002;
            ys[k] = 32'h00030004;
        end
        run_job("after_rst", 1, 32'h00010001, 0, 0, 0, 1'b0, 32'hFFFC000B, 3);

        for (int j = 0; j < 40; j++) begin
            int len;
            int sa;
            int sl;
            logic [31:0] init;
            len  = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 12));
            init = $urandom;
            for (int k = 0; k < len; k++) begin
                xs[k] = $urandom;
                ys[k] = $urandom;
            end
            sa = int'($urandom_range(0, 12));
            sl = int'($urandom_range(0, 3));
            run_job($sformatf("rand%0d", j), len, init, sa, sl, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), ref_dot(len, init),
                    (len == 0) ? 1 : len + 2 + ((sa < len) ? sl : 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
